// File: rtl/scoreboard_ctrl.sv
// Decode->exec issue scoreboard: combinational grant (RAW/WAW/capacity), registered pending/count/stall outputs.
// Define SCOREBOARD_WB_BYPASS_EN to let a retiring register satisfy a dependent issue in the same cycle.
module scoreboard_ctrl #(
  parameter int REG_CNT        = 32,
  parameter int REG_ADDR_WIDTH = $clog2(REG_CNT),
  parameter int MAX_INFLIGHT   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic                      issue_uses_rs1,
  input  logic                      issue_uses_rs2,
  input  logic                      issue_writes_rd,
  output logic                      issue_grant,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush_valid,
  input  logic [REG_ADDR_WIDTH-1:0] flush_rd,
  output logic [REG_CNT-1:0]        pending_mask,
  output logic [2:0]                inflight_cnt,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic                      underflow_err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

  logic [REG_CNT-1:0] retire_clear;
  logic [REG_CNT-1:0] eff;
  logic [REG_CNT-1:0] set_vec;
  logic [REG_CNT-1:0] pending_next;
  logic               raw1, raw2, waw, full;
  logic [3:0]         cnt_sum, cnt_dec;
  logic               cnt_underflow;
  logic [2:0]         inflight_next;

  always_comb begin
    retire_clear = '0;
    if (wb_valid)    retire_clear[wb_rd]    = 1'b1;
    if (flush_valid) retire_clear[flush_rd] = 1'b1;
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign eff = pending_mask & ~retire_clear;
`else
  assign eff = pending_mask;
`endif

  // x0 is never tracked, so hazards on it are masked explicitly as well
  assign raw1 = issue_uses_rs1  && (issue_rs1 != '0) && eff[issue_rs1];
  assign raw2 = issue_uses_rs2  && (issue_rs2 != '0) && eff[issue_rs2];
  assign waw  = issue_writes_rd && (issue_rd  != '0) && eff[issue_rd];
  assign full = (inflight_cnt == MAX_CNT) && !wb_valid && !flush_valid;

  assign issue_grant = issue_valid && !rst && !raw1 && !raw2 && !waw && !full;

  always_comb begin
    set_vec = '0;
    if (issue_grant && issue_writes_rd && (issue_rd != '0))
      set_vec[issue_rd] = 1'b1;
    // set is ORed after the clear so a same-cycle reissue of rd wins
    pending_next    = (pending_mask & ~retire_clear) | set_vec;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    cnt_sum       = {1'b0, inflight_cnt} + {3'b000, issue_grant};
    cnt_dec       = {3'b000, wb_valid} + {3'b000, flush_valid};
    cnt_underflow = cnt_dec > cnt_sum;
    inflight_next = cnt_underflow ? 3'd0 : 3'(cnt_sum - cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_mask  <= '0;
      inflight_cnt  <= '0;
      stall_cycles  <= '0;
      underflow_err <= 1'b0;
    end else begin
      pending_mask  <= pending_next;
      inflight_cnt  <= inflight_next;
      if (cnt_underflow)
        underflow_err <= 1'b1;
      if (issue_valid && !issue_grant && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
Issue scheduler between decode and execute in the multi-cycle RV32I core. Tracks which architectural registers have an in-flight write, and grants decode→exec issue only when there are no RAW or WAW hazards and in-flight capacity remains. Writeback retires entries and branch/jump flushes release them. Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_CNT, 32, number of architectural registers; x0 is hardwired zero
REG_ADDR_WIDTH, $clog2(REG_CNT), register index width
MAX_INFLIGHT, 2, maximum issued-but-unretired instructions (1..7)
CNT_WIDTH, 16, width of the stall counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
issue_valid  in  1  decode holds a decoded instruction awaiting issue
issue_rd  in  REG_ADDR_WIDTH  destination register
issue_rs1  in  REG_ADDR_WIDTH  source 1
issue_rs2  in  REG_ADDR_WIDTH  source 2
issue_uses_rs1  in  1  instruction reads rs1
issue_uses_rs2  in  1  instruction reads rs2
issue_writes_rd  in  1  instruction writes rd (0 for STORE/BRANCH)
issue_grant  out  1  issue accepted this cycle (combinational)
wb_valid  in  1  one-cycle pulse: an instruction retires through writeback
wb_rd  in  REG_ADDR_WIDTH  register retired
flush_valid  in  1  one-cycle pulse: exec drops its instruction without writeback
flush_rd  in  REG_ADDR_WIDTH  rd of the dropped instruction
pending_mask  out  REG_CNT  registered pending-write bit per register
inflight_cnt  out  3  registered count of issued, unretired instructions
stall_cycles  out  CNT_WIDTH  saturating count of stalled issue cycles
underflow_err  out  1  sticky; set when a retire/flush arrives while inflight_cnt==0

Behaviour:
- Reset (synchronous, rst=1 at posedge): pending_mask=0, inflight_cnt=0, stall_cycles=0, underflow_err=0. issue_grant=0 while rst=1. Reset mid-operation discards all tracking.
- Hazard terms use the effective pending vector `eff` (see Optional Feature):
  - raw1 = issue_uses_rs1 & eff[issue_rs1]
  - raw2 = issue_uses_rs2 & eff[issue_rs2]
  - waw = issue_writes_rd & eff[issue_rd]
- Full condition: full = (inflight_cnt == MAX_INFLIGHT) and no wb_valid/flush_valid in the same cycle. A same-cycle retire always frees a slot.
- issue_grant = issue_valid & !rst & !raw1 & !raw2 & !waw & !full. Zero-latency, combinational.
- Register 0 never becomes pending: writes targeting x0 are ignored, and hazards on x0 are always 0.
- Next-state of each pending bit, in priority order:
  - set if granted & issue_writes_rd & issue_rd==i & i!=0;
  - else clear if (wb_valid & wb_rd==i) | (flush_valid & flush_rd==i);
  - else hold.
  - Set beats clear for the same register in the same cycle.
- inflight_cnt next = cnt + grant − wb_valid − flush_valid.
  - Any decrement that would go below 0 clamps at 0 and sets underflow_err.
  - Grants with issue_writes_rd=0 still occupy a slot; such instructions must still pulse wb_valid, with wb_rd=0, at completion.
- stall_cycles increments each cycle with issue_valid & !issue_grant, and saturates at all-ones.
- wb_valid and flush_valid may be asserted together, for different instructions. Both clears and both decrements apply.
- No state machine beyond the scoreboard and counters. All outputs except issue_grant are registered.

Optional Feature:
Macro SCOREBOARD_WB_BYPASS_EN.
- Defined: eff = pending_mask & ~retire_clear, where retire_clear is the same-cycle one-hot of wb_rd (if wb_valid) OR flush_rd (if flush_valid). An instruction dependent on the retiring register is granted in the retire cycle.
- Undefined: eff = pending_mask. The dependent instruction is granted one cycle after retire.
- The full condition is identical in both builds.

Test Plan:
- Reset, then issue_valid with rd=5, writes_rd=1 → issue_grant=1 same cycle; next cycle pending_mask=0x20, inflight_cnt=1.
- With pending[5] set, issue rs1=5, uses_rs1=1 → grant=0 and stall_cycles increments each cycle. When wb_valid/wb_rd=5 arrives: with bypass, grant=1 in that cycle; without bypass, grant=1 one cycle later.
- Issue rd=0, writes_rd=1 → pending_mask stays 0 and a later read of x0 is never stalled; inflight_cnt=1 until a wb_valid with wb_rd=0.
- MAX_INFLIGHT=2: two independent grants (rd=1, rd=2), then a third issue → grant=0 (full). Pulse wb_valid with wb_rd=1 → third grant=1 that same cycle; inflight_cnt stays 2.
- With rd=3 in flight, flush_valid/flush_rd=3 → pending[3]=0 and inflight_cnt decrements. A second flush at cnt=0 → cnt stays 0 and underflow_err=1 (sticky until rst).
- Hold issue_valid stalled for 70000 cycles with CNT_WIDTH=16 → stall_cycles=0xFFFF. Assert rst mid-run → all outputs return to 0 on the next edge.
